mem_io_responder: RTL
=====================

Name: mem_io_responder

Overview:
- Slave end of the CPU byte-wide memory bus (address, write strobe, data out, data in). Holds the 128 KB program/data RAM and decodes the I/O window (addr[17:16]==2'b11): UART tx byte port, optional rx byte port, cycle counter and program-stop.
- Returns read data one cycle after the request.
- Drives io_buffer_full back to the CPU from a tx FIFO that drains to the UART side.

Parameters:
RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB)
TX_DEPTH, 16, tx FIFO depth in bytes (power of 2, >=4)
FULL_MARGIN, 2, io_buffer_full asserts when free slots <= FULL_MARGIN

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  bus enable; when low, no access is performed and the counter holds
mem_a  in  32  byte address from CPU (bits 17:0 decoded)
mem_wr  in  1  1 = write, 0 = read
cpu_dout  in  8  write data from CPU
mem_din  out  8  read data to CPU, valid one cycle after request
io_buffer_full  out  1  tx FIFO near full
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx FIFO non-empty
tx_ready  in  1  UART accepts tx_data this cycle
rx_data  in  8  byte from UART receiver (IO_RX_EN only)
rx_valid  in  1  rx byte available (IO_RX_EN only)
rx_pop  out  1  one-cycle pulse consuming rx_data (IO_RX_EN only)
program_stop  out  1  sticky, set by a write to 0x30004

Behaviour:
- Reset (rst_n_in low, async):
  - mem_din=0, tx_valid=0, io_buffer_full=0, rx_pop=0, program_stop=0.
  - FIFO pointers/count=0, cycle counter=0, counter snapshot=0.
  - RAM contents undefined (not cleared).
- Decode, evaluated only when rdy_in=1:
  - RAM when addr[17:16]!=2'b11.
  - IO when addr[17:16]==2'b11, with sub-address addr[2:0].
- RAM read: mem_din <= ram[addr[RAM_ADDR_W-1:0]] at the clock edge. Latency exactly 1 cycle.
- RAM write: ram[addr] <= cpu_dout at the edge. mem_din holds its previous value.
- IO write 0x30000:
  - cpu_dout != 0 pushes to the tx FIFO; 0x00 is dropped.
  - A push when the FIFO is full is dropped.
- IO write 0x30004: program_stop <= 1, sticky until reset. Data ignored.
- IO read 0x30000: with IO_RX_EN, see Optional Feature; without it, mem_din <= 0.
- IO read 0x30004..0x30007 (cycle counter):
  - Read of 0x30004 snapshots the counter and returns snapshot[7:0] the next cycle.
  - 0x30005/6/7 return snapshot bytes 1/2/3 from the held snapshot, so the word is coherent.
- Other IO addresses: reads return 0, writes are ignored.
- Cycle counter:
  - 32-bit, increments each clock with rdy_in=1 and program_stop=0.
  - Wraps 0xFFFFFFFF -> 0.
- tx FIFO:
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and count is unchanged.
  - Same cycle on empty: the pushed byte appears on tx_data the next cycle, not bypassed.
- io_buffer_full is registered: 1 when (TX_DEPTH - count_next) <= FULL_MARGIN. The margin absorbs CPU pipeline lag.
- rdy_in=0: no RAM or IO side effects, mem_din holds. The tx drain continues.

Optional Feature:
- Macro IO_RX_EN.
- Defined:
  - A read of 0x30000 returns rx_data when rx_valid=1 and pulses rx_pop for that same cycle.
  - It returns 0 with no pop when rx_valid=0.
  - Back-to-back reads pop at most once per cycle.
- Undefined: the rx ports are still present but ignored, rx_pop is tied 0, and reads of 0x30000 return 0.

Decomposition:
- Shared package (io_map): constants
  - IO_SEL = 2'b11
  - IO_PORT_UART = 3'h0
  - IO_PORT_CLK = 3'h4
  - RAM_SIZE_BYTES
  - defaults for TX_DEPTH and FULL_MARGIN
- Sub-module byte_fifo (parameter DEPTH): push/pop/count/full/empty. It is instantiated for tx and is reusable for rx buffering later.

Test Plan:
- Write 0x00123=0xA5, then read 0x00123 -> mem_din=0xA5 exactly 1 cycle after the read request. Read of an unwritten neighbour does not disturb it.
- Write 0x30000 with 'H', 0x00, 'i', tx_ready=1 -> tx_data sequence 'H','i' only. tx_valid is low after the drain.
- tx_ready=0, 14 pushes (DEPTH 16, margin 2) -> io_buffer_full=1 after the 14th. The 17th push is dropped. Raising tx_ready drains 16 bytes in order and io_buffer_full deasserts.
- After 1000 rdy cycles, read 0x30004..0x30007 -> bytes form the counter value at the 0x30004 read, little-endian. Counter increments continue between reads without tearing.
- Write 0x30004 -> program_stop=1 next cycle. The counter freezes. A write to 0x30000 still pushes. Async reset mid-run clears program_stop and all outputs immediately.
- rdy_in=0 for 5 cycles with a write to RAM presented -> RAM is unchanged and the counter holds. (IO_RX_EN) rx_valid=1, rx_data=0x41, read 0x30000 -> mem_din=0x41 and a single rx_pop pulse.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// I/O map shared by the memory/IO responder and its sub-blocks.
//   IO_SEL          : value of addr[17:16] that selects the I/O window
//   IO_PORT_UART    : sub-address addr[2:0] of the UART byte port
//   IO_PORT_CLK     : sub-address addr[2:0] of the cycle counter / program stop
//   RAM_SIZE_BYTES  : size of the default program/data RAM
//   *_DEF           : default parameter values for the responder
// Helper: snap_byte() selects one byte of a 32-bit counter snapshot.
package mem_io_responder_pkg;

  localparam logic [1:0] IO_SEL       = 2'b11;
  localparam logic [2:0] IO_PORT_UART = 3'h0;
  localparam logic [2:0] IO_PORT_CLK  = 3'h4;

  localparam int RAM_ADDR_W_DEF  = 17;
  localparam int RAM_SIZE_BYTES  = 1 << RAM_ADDR_W_DEF;
  localparam int TX_DEPTH_DEF    = 16;
  localparam int FULL_MARGIN_DEF = 2;

  // Little-endian byte select out of a held 32-bit snapshot.
  function automatic logic [7:0] snap_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: synchronous byte FIFO, DEPTH entries (power of 2).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write request and byte; dropped when full unless a
//                         pop frees a slot in the same cycle
//   pop                 : read request; ignored when empty
//   pop_data            : head of the FIFO (valid while !empty)
//   count, count_next   : current occupancy and occupancy after this edge
//   full, empty         : occupancy flags (derived from the registered count)
// No bypass: a byte pushed into an empty FIFO is visible the next cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_s, pop_s;

  assign empty      = (count_q == {(AW+1){1'b0}});
  assign full       = (count_q == DEPTH_C);
  assign pop_s      = pop && !empty;
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign push_s     = push && (!full || pop_s);
  assign pop_data   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: slave end of the CPU byte-wide memory bus.
// Holds the program/data RAM and decodes the I/O window (addr[17:16]==2'b11):
//   0x30000 write : push byte to tx FIFO (0x00 dropped)
//   0x30000 read  : rx byte (IO_RX_EN) or 0
//   0x30004 write : set sticky program_stop
//   0x30004 read  : snapshot cycle counter, return byte 0; 0x30005..7 return
//                   bytes 1..3 of the held snapshot
// Ports:
//   clk_in, rst_n_in      : clock, asynchronous active-low reset
//   rdy_in                : bus enable; low = no access, counter holds
//   mem_a, mem_wr, cpu_dout : request address, write flag, write data
//   mem_din               : read data, one cycle after the request
//   io_buffer_full        : registered tx FIFO near-full flag
//   tx_data, tx_valid, tx_ready : tx FIFO drain to the UART
//   rx_data, rx_valid, rx_pop   : UART receive byte port
//   program_stop          : sticky stop flag
// Build option: define IO_RX_EN to enable the rx byte port; when undefined
// the rx inputs are ignored, rx_pop is 0 and reads of 0x30000 return 0.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W  = RAM_ADDR_W_DEF,
  parameter int TX_DEPTH    = TX_DEPTH_DEF,
  parameter int FULL_MARGIN = FULL_MARGIN_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop
);

  localparam int RAM_SIZE = 1 << RAM_ADDR_W;
  localparam int CW       = $clog2(TX_DEPTH) + 1;
  // Free slots <= FULL_MARGIN  <=>  count >= TX_DEPTH - FULL_MARGIN.
  localparam logic [CW-1:0] FULL_AT = CW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0] ram_q [RAM_SIZE];

  logic [7:0]  mem_din_q, mem_din_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        program_stop_q, program_stop_d;
  logic        io_buffer_full_q, io_buffer_full_d;

  logic [RAM_ADDR_W-1:0] ram_addr_s;
  logic [2:0]  sub_s;
  logic        ram_sel_s, io_sel_s;
  logic        ram_we_s, ram_rd_s;
  logic        tx_push_s, stop_wr_s;
  logic        rd_uart_s, rd_clk_s, rd_other_s;
  logic [7:0]  rx_rd_data_s;
  logic        tx_pop_s, tx_full_s, tx_empty_s;
  logic [CW-1:0] tx_count_s, tx_count_next_s;
  logic        unused_s;

  // Address decode; nothing is selected while rdy_in is low.
  assign ram_addr_s = mem_a[RAM_ADDR_W-1:0];
  assign sub_s      = mem_a[2:0];
  assign ram_sel_s  = rdy_in && (mem_a[17:16] != IO_SEL);
  assign io_sel_s   = rdy_in && (mem_a[17:16] == IO_SEL);
  assign ram_we_s   = ram_sel_s && mem_wr;
  assign ram_rd_s   = ram_sel_s && !mem_wr;
  assign tx_push_s  = io_sel_s && mem_wr && (sub_s == IO_PORT_UART) && (cpu_dout != 8'h00);
  assign stop_wr_s  = io_sel_s && mem_wr && (sub_s == IO_PORT_CLK);
  assign rd_uart_s  = io_sel_s && !mem_wr && (sub_s == IO_PORT_UART);
  assign rd_clk_s   = io_sel_s && !mem_wr && sub_s[2];
  assign rd_other_s = io_sel_s && !mem_wr && !sub_s[2] && (sub_s != IO_PORT_UART);

`ifdef IO_RX_EN
  // Pop in the request cycle so back-to-back reads consume one byte each.
  assign rx_pop       = rd_uart_s && rx_valid && rst_n_in;
  assign rx_rd_data_s = rx_valid ? rx_data : 8'h00;
  assign unused_s     = ^{mem_a[31:18], tx_count_s, tx_full_s};
`else
  assign rx_pop       = 1'b0;
  assign rx_rd_data_s = 8'h00;
  assign unused_s     = ^{mem_a[31:18], tx_count_s, tx_full_s, rx_data, rx_valid};
`endif

  assign tx_pop_s = tx_valid && tx_ready;

  byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .push       (tx_push_s),
    .push_data  (cpu_dout),
    .pop        (tx_pop_s),
    .pop_data   (tx_data),
    .count      (tx_count_s),
    .count_next (tx_count_next_s),
    .full       (tx_full_s),
    .empty      (tx_empty_s)
  );

  assign tx_valid = !tx_empty_s;

  // Read data, counter snapshot, counter, stop flag and near-full flag.
  always_comb begin
    mem_din_d        = mem_din_q;
    snap_d           = snap_q;
    cnt_d            = cnt_q;
    program_stop_d   = program_stop_q;
    io_buffer_full_d = (tx_count_next_s >= FULL_AT);

    if (ram_rd_s) begin
      mem_din_d = ram_q[ram_addr_s];
    end else if (rd_clk_s) begin
      // Byte 0 captures the counter; bytes 1..3 come from that capture.
      if (sub_s == IO_PORT_CLK) begin
        snap_d    = cnt_q;
        mem_din_d = cnt_q[7:0];
      end else begin
        mem_din_d = snap_byte(snap_q, sub_s[1:0]);
      end
    end else if (rd_uart_s) begin
      mem_din_d = rx_rd_data_s;
    end else if (rd_other_s) begin
      mem_din_d = 8'h00;
    end else begin
      mem_din_d = mem_din_q;
    end

    if (rdy_in && !program_stop_q) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (stop_wr_s) begin
      program_stop_d = 1'b1;
    end else begin
      program_stop_d = program_stop_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din_q        <= 8'h00;
      cnt_q            <= 32'h0000_0000;
      snap_q           <= 32'h0000_0000;
      program_stop_q   <= 1'b0;
      io_buffer_full_q <= 1'b0;
    end else begin
      mem_din_q        <= mem_din_d;
      cnt_q            <= cnt_d;
      snap_q           <= snap_d;
      program_stop_q   <= program_stop_d;
      io_buffer_full_q <= io_buffer_full_d;
    end
  end

  // RAM storage; contents are deliberately not cleared by reset.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_q[ram_addr_s] <= cpu_dout;
    end
  end

  assign mem_din        = mem_din_q;
  assign program_stop   = program_stop_q;
  assign io_buffer_full = io_buffer_full_q;

endmodule
